conv2_feeder: RTL and testbench

CONV2_FEEDER -- requirements
Module: conv2_feeder

---
 rtl/conv2_feeder.sv | 238 +++++++++++++++++++++++
 tb/tb_conv2_feeder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_feeder.sv
// conv2_feeder
// Feeds a convolution engine. A WIDTH*HEIGHT four-channel pixel buffer is
// filled while the block is idle. A job request optionally replays the whole
// kernel set from an external kernel source (KW words), waits for the
// consumer to confirm the kernels are stored, and then streams every pixel
// in raster order with all four channels in parallel.
//
// Ports
//   clk              rising-edge clock
//   resetn           synchronous reset, active high (1 = reset)
//   wr_en/wr_addr    pixel buffer write (ignored while busy)
//   wr_data0..3      channel 0..3 write data
//   start            job request, only accepted in IDLE
//   reload_kernel    sampled with start: send kernels before streaming
//   k_addr/k_rdata   kernel source read port (one-cycle read latency)
//   load_kernel      kernel word valid to consumer, kernel = word
//   load_kernel_done consumer acknowledge that all kernels are stored
//   valid_out        pixel valid, data_out0..3 = channel data
//   busy             high whenever not IDLE
//   done             one-cycle pulse in the final state of a job
module conv2_feeder #(
    parameter int WIDTH      = 16,
    parameter int HEIGHT     = 16,
    parameter int CHANEL     = 4,
    parameter int NUM_KERNEL = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [31:0] wr_data0,
    input  logic [31:0] wr_data1,
    input  logic [31:0] wr_data2,
    input  logic [31:0] wr_data3,
    input  logic        start,
    input  logic        reload_kernel,
    output logic [8:0]  k_addr,
    input  logic [31:0] k_rdata,
    output logic        load_kernel,
    output logic [31:0] kernel,
    input  logic        load_kernel_done,
    output logic        valid_out,
    output logic [31:0] data_out0,
    output logic [31:0] data_out1,
    output logic [31:0] data_out2,
    output logic [31:0] data_out3,
    output logic        busy,
    output logic        done
);

    localparam int          NPIX      = WIDTH * HEIGHT;
    localparam int          KW        = NUM_KERNEL * CHANEL * 9;
    localparam logic [31:0] NPIX_32   = 32'(NPIX);
    localparam logic [7:0]  PIX_LAST  = 8'(NPIX - 1);
    localparam logic [8:0]  KW_LAST   = 9'(KW - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KLOAD  = 3'd1,
        ST_KWAIT  = 3'd2,
        ST_STREAM = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

    // Pixel buffer: one 128-bit word holds all four channels {ch3,ch2,ch1,ch0}.
    logic [127:0] buf_mem [0:NPIX-1];

    state_t       state_r;
    state_t       state_s;
    logic [8:0]   k_addr_r;
    logic [8:0]   k_addr_s;
    logic         k_drain_r;
    logic         k_drain_s;
    logic         k_issue_s;
    logic         load_kernel_r;
    logic         ack_r;
    logic         ack_s;
    logic [7:0]   rd_addr_r;
    logic [7:0]   rd_addr_s;
    logic         s_drain_r;
    logic         s_drain_s;
    logic         rd_issue_s;
    logic         valid_r;
    logic [127:0] pix_r;
    logic         busy_r;
    logic         done_r;
    logic         wr_ok_s;

    // Buffer write qualification: only while idle and inside the buffer.
    always_comb begin
        wr_ok_s = wr_en && (state_r == ST_IDLE) && ({24'd0, wr_addr} < NPIX_32);
    end

    // Pixel buffer write port; reset deliberately leaves contents intact.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            buf_mem[wr_addr] <= {wr_data3, wr_data2, wr_data1, wr_data0};
        end
    end

    // Next-state and counter logic. Each phase ends with a one-cycle drain
    // so the last word/pixel (returned one cycle after its address) still
    // belongs to the phase that issued it.
    always_comb begin
        state_s    = state_r;
        k_addr_s   = k_addr_r;
        k_drain_s  = k_drain_r;
        rd_addr_s  = rd_addr_r;
        s_drain_s  = s_drain_r;
        k_issue_s  = 1'b0;
        rd_issue_s = 1'b0;
        // An acknowledge arriving any time during the kernel phase is kept.
        if ((state_r == ST_KLOAD) || (state_r == ST_KWAIT)) begin
            ack_s = ack_r | load_kernel_done;
        end else begin
            ack_s = ack_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (reload_kernel) begin
                        state_s   = ST_KLOAD;
                        k_addr_s  = 9'd0;
                        k_drain_s = 1'b0;
                        ack_s     = 1'b0;
                    end else begin
                        state_s   = ST_STREAM;
                        rd_addr_s = 8'd0;
                        s_drain_s = 1'b0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_KLOAD: begin
                if (k_drain_r) begin
                    state_s   = ST_KWAIT;
                    k_drain_s = 1'b0;
                end else begin
                    k_issue_s = 1'b1;
                    if (k_addr_r == KW_LAST) begin
                        k_drain_s = 1'b1;
                        k_addr_s  = 9'd0;
                    end else begin
                        k_addr_s  = k_addr_r + 9'd1;
                    end
                end
            end
            ST_KWAIT: begin
                if (ack_r || load_kernel_done) begin
                    state_s   = ST_STREAM;
                    rd_addr_s = 8'd0;
                    s_drain_s = 1'b0;
                    ack_s     = 1'b0;
                end else begin
                    state_s = ST_KWAIT;
                end
            end
            ST_STREAM: begin
                if (s_drain_r) begin
                    state_s   = ST_FIN;
                    s_drain_s = 1'b0;
                end else begin
                    rd_issue_s = 1'b1;
                    if (rd_addr_r == PIX_LAST) begin
                        s_drain_s = 1'b1;
                        rd_addr_s = 8'd0;
                    end else begin
                        rd_addr_s = rd_addr_r + 8'd1;
                    end
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                k_addr_s  = 9'd0;
                k_drain_s = 1'b0;
                rd_addr_s = 8'd0;
                s_drain_s = 1'b0;
                ack_s     = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; busy/done follow the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_r       <= ST_IDLE;
            k_addr_r      <= 9'd0;
            k_drain_r     <= 1'b0;
            load_kernel_r <= 1'b0;
            ack_r         <= 1'b0;
            rd_addr_r     <= 8'd0;
            s_drain_r     <= 1'b0;
            valid_r       <= 1'b0;
            pix_r         <= 128'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            k_addr_r      <= k_addr_s;
            k_drain_r     <= k_drain_s;
            load_kernel_r <= k_issue_s;
            ack_r         <= ack_s;
            rd_addr_r     <= rd_addr_s;
            s_drain_r     <= s_drain_s;
            valid_r       <= rd_issue_s;
            pix_r         <= rd_issue_s ? buf_mem[rd_addr_r] : 128'd0;
            busy_r        <= (state_s != ST_IDLE);
            done_r        <= (state_s == ST_FIN);
        end
    end

    // The kernel source already has a one-cycle read latency, so the word is
    // passed straight through, gated to zero outside load_kernel cycles.
    always_comb begin
        if (load_kernel_r) begin
            kernel = k_rdata;
        end else begin
            kernel = 32'd0;
        end
    end

    assign k_addr      = k_addr_r;
    assign load_kernel = load_kernel_r;
    assign valid_out   = valid_r;
    assign data_out0   = pix_r[31:0];
    assign data_out1   = pix_r[63:32];
    assign data_out2   = pix_r[95:64];
    assign data_out3   = pix_r[127:96];
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_conv2_feeder.sv
// Directed self-checking bench for conv2_feeder at default parameters.
module tb_conv2_feeder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data0, wr_data1, wr_data2, wr_data3;
    logic        start;
    logic        reload_kernel;
    logic [8:0]  k_addr;
    logic [31:0] k_rdata;
    logic        load_kernel;
    logic [31:0] kernel;
    logic        load_kernel_done;
    logic        valid_out;
    logic [31:0] data_out0, data_out1, data_out2, data_out3;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_err = 0;

    conv2_feeder dut (
        .clk              (clk),
        .resetn           (resetn),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data0         (wr_data0),
        .wr_data1         (wr_data1),
        .wr_data2         (wr_data2),
        .wr_data3         (wr_data3),
        .start            (start),
        .reload_kernel    (reload_kernel),
        .k_addr           (k_addr),
        .k_rdata          (k_rdata),
        .load_kernel      (load_kernel),
        .kernel           (kernel),
        .load_kernel_done (load_kernel_done),
        .valid_out        (valid_out),
        .data_out0        (data_out0),
        .data_out1        (data_out1),
        .data_out2        (data_out2),
        .data_out3        (data_out3),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    // Kernel source model: word = address + 100, one-cycle read latency.
    always @(posedge clk) begin
        k_rdata <= {23'd0, k_addr} + 32'd100;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pix(input int ch, input int i);
        return 32'(ch * 1000 + i);
    endfunction

    task automatic issue_start(input logic rk);
        start         = 1'b1;
        reload_kernel = rk;
        tick();
        start         = 1'b0;
        reload_kernel = 1'b0;
    endtask

    // Kernel phase check. ack_at >= 0 pulses the acknowledge during that
    // word; otherwise the acknowledge is withheld 20 cycles, then pulsed.
    task automatic kload(input int ack_at);
        int w;
        int bad;
        w = 0;
        while (!load_kernel && w < 8) begin
            tick();
            w++;
        end
        chk("k_latency", w, 1);
        bad = 0;
        for (int j = 0; j < 288; j++) begin
            if (!load_kernel || kernel !== 32'(100 + j) || valid_out) bad++;
            if (j == ack_at) load_kernel_done = 1'b1;
            tick();
            load_kernel_done = 1'b0;
        end
        chk("k_seq_bad", bad, 0);
        chk("k_after_load", {31'd0, load_kernel}, 0);
        chk("k_after_kernel", kernel, 0);
        chk("k_after_busy", {31'd0, busy}, 1);
        if (ack_at < 0) begin
            bad = 0;
            for (int j = 0; j < 20; j++) begin
                if (valid_out || load_kernel) bad++;
                tick();
            end
            chk("kwait_quiet", bad, 0);
            load_kernel_done = 1'b1;
            tick();
            load_kernel_done = 1'b0;
        end
    endtask

    // Stream phase check. exp_lat < 0 skips the latency comparison; lock_at
    // injects start+write at that pixel; rst_at resets at that pixel.
    task automatic stream(input int exp_lat, input int lock_at, input int rst_at);
        int w;
        int bad;
        w = 0;
        while (!valid_out && w < 40) begin
            tick();
            w++;
        end
        if (exp_lat >= 0) chk("s_latency", w, exp_lat);
        else chk("s_found", {31'd0, valid_out}, 1);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (!valid_out || load_kernel || done ||
                data_out0 !== pix(0, i) || data_out1 !== pix(1, i) ||
                data_out2 !== pix(2, i) || data_out3 !== pix(3, i)) bad++;
            if (i == rst_at) begin
                chk("s_seq_bad_pre_rst", bad, 0);
                resetn = 1'b1;
                tick();
                resetn = 1'b0;
                chk("rst_valid", {31'd0, valid_out}, 0);
                chk("rst_busy", {31'd0, busy}, 0);
                chk("rst_data2", data_out2, 0);
                chk("rst_data0", data_out0, 0);
                tick();
                chk("rst_idle_busy", {31'd0, busy}, 0);
                return;
            end
            if (i == lock_at) begin
                start         = 1'b1;
                wr_en         = 1'b1;
                wr_addr       = 8'd5;
                wr_data0      = 32'hDEAD;
                wr_data1      = 32'hDEAD;
                wr_data2      = 32'hDEAD;
                wr_data3      = 32'hDEAD;
            end
            tick();
            start = 1'b0;
            wr_en = 1'b0;
        end
        chk("s_seq_bad", bad, 0);
        chk("end_valid", {31'd0, valid_out}, 0);
        chk("end_data2", data_out2, 0);
        chk("end_done", {31'd0, done}, 1);
        tick();
        chk("end_done_pulse", {31'd0, done}, 0);
        chk("end_busy", {31'd0, busy}, 0);
        tick();
        chk("end_still_idle", {31'd0, busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        resetn           = 1'b1;
        wr_en            = 1'b0;
        wr_addr          = 8'd0;
        wr_data0         = 32'd0;
        wr_data1         = 32'd0;
        wr_data2         = 32'd0;
        wr_data3         = 32'd0;
        start            = 1'b0;
        reload_kernel    = 1'b0;
        load_kernel_done = 1'b0;
        repeat (3) tick();
        chk("rst_k_addr", {23'd0, k_addr}, 0);
        chk("rst_load_kernel", {31'd0, load_kernel}, 0);
        chk("rst_kernel", kernel, 0);
        chk("rst_valid_out", {31'd0, valid_out}, 0);
        chk("rst_data_out3", data_out3, 0);
        chk("rst_busy0", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        resetn = 1'b0;
        tick();

        // Fill the buffer: chN[i] = N*1000 + i.
        for (int i = 0; i < 256; i++) begin
            wr_en    = 1'b1;
            wr_addr  = 8'(i);
            wr_data0 = pix(0, i);
            wr_data1 = pix(1, i);
            wr_data2 = pix(2, i);
            wr_data3 = pix(3, i);
            tick();
        end
        wr_en = 1'b0;
        tick();

        // Kernel load with acknowledge withheld, then stream.
        issue_start(1'b1);
        chk("busy_after_start", {31'd0, busy}, 1);
        kload(-1);
        stream(1, -1, -1);

        // Kernel load with early acknowledge at word 50.
        issue_start(1'b1);
        kload(50);
        stream(-1, -1, -1);

        // Direct stream; start and write during streaming must be ignored.
        issue_start(1'b0);
        stream(1, 10, -1);
        issue_start(1'b0);
        stream(1, -1, -1);

        // Reset mid-stream at pixel 100, then a clean full stream.
        issue_start(1'b0);
        stream(1, -1, 100);
        issue_start(1'b0);
        stream(1, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
